// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants, responder FSM encodings and address helpers.
package sysbus_pkg;

  localparam int SYSBUS_WIDTH     = 64;
  localparam int SYSBUS_TAG_WIDTH = 13;
  localparam int TAG_WRITE_BIT    = SYSBUS_TAG_WIDTH - 1;
  localparam int SYSBUS_BEATS     = 8;

  // A 64-byte line: bits [2:0] select a byte, [5:3] a word, [6+] the line.
  localparam int WORD_LSB = 3;
  localparam int LINE_LSB = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Upper address bits beyond line_bits alias onto the same storage.
  function automatic logic [63:0] line_index(input logic [63:0] addr,
                                             input int unsigned line_bits);
    return (addr >> LINE_LSB) & ((64'd1 << line_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response bundle between the cache arbiter and a memory responder.
interface sysbus_mem_responder_if #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13
);
  // Handshake: a request or write beat is held on req/reqtag with reqcyc=1
  // until the responder pulses reqack; a response beat stays on resp with
  // respcyc=1 until the requester returns respack=1 while respcyc is high.
  logic [WIDTH-1:0]     req;
  logic [TAG_WIDTH-1:0] reqtag;
  logic                 reqcyc;
  logic                 reqack;
  logic [WIDTH-1:0]     resp;
  logic [TAG_WIDTH-1:0] resptag;
  logic                 respcyc;
  logic                 respack;

  modport master (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );

  modport slave (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );
endinterface

// File: rtl/sysbus_mem_array.sv
// Single-port line storage: synchronous write, combinational read at {line, word}.
module sysbus_mem_array #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: one line read or write at a time, fixed read latency.
// Build option SYSBUS_MEM_CRITICAL_WORD_FIRST_EN starts reads at the requested word.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int WIDTH     = SYSBUS_WIDTH,
  parameter int TAG_WIDTH = SYSBUS_TAG_WIDTH,
  parameter int BEATS     = SYSBUS_BEATS,
  parameter int LINES     = 1024,
  parameter int LATENCY   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  sysbus_mem_responder_if.slave  bus,
  output logic [1:0]             dbg_state
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = $clog2(LINES);
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int ADDR_W = LINE_W + BEAT_W;

  logic [1:0]           state;
  logic [LINE_W-1:0]    line_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [BEAT_W-1:0]    beat;
  logic [BEAT_W-1:0]    sent;
  logic [LAT_W-1:0]     lat_cnt;

  logic [BEAT_W-1:0]    first_word;
  logic [BEAT_W-1:0]    next_beat;
  logic [BEAT_W-1:0]    rd_word;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 is_write;

  assign is_write  = bus.reqtag[TAG_WIDTH-1];
  assign next_beat = beat + BEAT_W'(1);
  assign dbg_state = state;

`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
  logic [BEAT_W-1:0] offset_q;
  assign first_word = offset_q;

  always_ff @(posedge clk) begin
    if (reset) offset_q <= '0;
    else if (state == ST_IDLE && bus.reqcyc) offset_q <= bus.req[WORD_LSB +: BEAT_W];
  end
`else
  assign first_word = '0;
`endif

  // The single port serves the write beat in WDATA; otherwise it looks ahead
  // to the word that the registered resp will show next cycle.
  always_comb begin
    rd_word  = (state == ST_WAIT) ? first_word : next_beat;
    mem_we   = 1'b0;
    mem_addr = {line_q, rd_word};
    if (state == ST_WDATA) begin
      mem_addr = {line_q, beat};
      mem_we   = bus.reqcyc && !reset;
    end
  end

  sysbus_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (BEATS * LINES),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(bus.req),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      beat        <= '0;
      sent        <= '0;
      lat_cnt     <= '0;
      bus.reqack  <= 1'b0;
      bus.respcyc <= 1'b0;
      bus.resp    <= '0;
      bus.resptag <= '0;
    end else begin
      bus.reqack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.reqcyc) begin
            line_q     <= LINE_W'(line_index(64'(bus.req), LINE_W));
            tag_q      <= bus.reqtag;
            bus.reqack <= 1'b1;
            beat       <= '0;
            sent       <= '0;
            if (is_write) begin
              state <= ST_WDATA;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= LAT_W'(LATENCY - 1);
            end
          end
        end
        ST_WDATA: begin
          if (bus.reqcyc) begin
            bus.reqack <= 1'b1;
            beat       <= next_beat;
            if (beat == BEAT_W'(BEATS - 1)) state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state       <= ST_RESP;
            bus.respcyc <= 1'b1;
            bus.resp    <= mem_rdata;
            bus.resptag <= tag_q;
            beat        <= first_word;
            sent        <= '0;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.respack) begin
            // The idle respcyc cycle after the last beat marks end of transfer.
            if (sent == BEAT_W'(BEATS - 1)) begin
              bus.respcyc <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              beat     <= next_beat;
              sent     <= sent + BEAT_W'(1);
              bus.resp <= mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder with a read-data scoreboard.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int LATENCY = 20;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mem_model [int];
  logic [63:0] wdata [8];

  sysbus_mem_responder_if #(.WIDTH(64), .TAG_WIDTH(13)) bus ();

  sysbus_mem_responder #(
    .WIDTH(64), .TAG_WIDTH(13), .BEATS(8), .LINES(1024), .LATENCY(LATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int mkey(input logic [63:0] addr, input int w);
    logic [12:0] k;
    k = {addr[15:6], 3'(w)};
    return int'(k);
  endfunction

  // Writes wdata[] to the line at addr; gap_len idle cycles are inserted before beat gap_at.
  task automatic write_line(input logic [63:0] addr, input logic [11:0] id,
                            input int gap_at, input int gap_len);
    logic prev;
    @(negedge clk);
    bus.req = addr; bus.reqtag = {1'b1, id}; bus.reqcyc = 1'b1; prev = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check("wr_ack", bus.reqack, prev);
          bus.reqcyc = 1'b0; bus.req = '0; prev = 1'b0;
        end
      end
      @(negedge clk);
      check("wr_ack", bus.reqack, prev);
      bus.req = wdata[b]; bus.reqcyc = 1'b1; prev = 1'b1;
      mem_model[mkey(addr, b)] = wdata[b];
    end
    @(negedge clk);
    check("wr_ack_last", bus.reqack, prev);
    bus.reqcyc = 1'b0; bus.req = '0;
    @(negedge clk);
    check("wr_ack_done", bus.reqack, 1'b0);
    check("wr_idle", dbg_state, ST_IDLE);
  endtask

  // Reads the line at addr; stalls respack for stall_len cycles on beat stall_beat
  // and, if reset_at >= 0, asserts reset while that beat is presented.
  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                           input int stall_beat, input int stall_len, input int reset_at);
    logic [2:0] off;
    logic [2:0] w;
    int cyc;
    int beats;
    int hold;
`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
    off = addr[5:3];
`else
    off = 3'd0;
`endif
    for (int k = 0; k < 8; k++) begin
      w = off + 3'(k);
      exp_q.push_back(mem_model.exists(mkey(addr, int'(w))) ? mem_model[mkey(addr, int'(w))] : 64'hx);
    end
    @(negedge clk);
    bus.req = addr; bus.reqtag = tag; bus.reqcyc = 1'b1;
    @(negedge clk);
    cyc = 1;
    check("rd_reqack", bus.reqack, 1'b1);
    bus.reqcyc = 1'b0; bus.req = '0;
    while (!bus.respcyc && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_latency", 64'(cyc), 64'(LATENCY + 1));
    beats = 0;
    hold  = 0;
    while (beats < 8 && cyc < 300) begin
      if (bus.respcyc) begin
        check("rd_tag", bus.resptag, tag);
        if (beats == reset_at) begin
          reset = 1'b1; bus.respack = 1'b0;
          @(negedge clk);
          check("rst_respcyc", bus.respcyc, 1'b0);
          check("rst_reqack", bus.reqack, 1'b0);
          check("rst_idle", dbg_state, ST_IDLE);
          reset = 1'b0;
          exp_q.delete();
          return;
        end
        if (beats == stall_beat && hold < stall_len) begin
          bus.respack = 1'b0;
          hold++;
          check("rd_hold", bus.resp, exp_q[0]);
        end else begin
          bus.respack = 1'b1;
          check("rd_beat", bus.resp, exp_q.pop_front());
          beats++;
        end
      end else begin
        bus.respack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.respack = 1'b0;
    check("rd_count", 64'(beats), 64'd8);
    check("rd_end_respcyc", bus.respcyc, 1'b0);
    @(negedge clk);
    check("rd_end_idle", dbg_state, ST_IDLE);
    check("rd_no_extra", bus.respcyc, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.reqtag = '0; bus.reqcyc = 1'b0; bus.respack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values held across idle cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_reqack", bus.reqack, 1'b0);
      check("idle_respcyc", bus.respcyc, 1'b0);
      check("idle_resp", bus.resp, 64'd0);
      check("idle_resptag", bus.resptag, 13'd0);
    end

    // Known line, continuous write, plain readback
    for (int b = 0; b < 8; b++) wdata[b] = 64'(8'h11 * (b + 1));
    write_line(64'h1000, 12'h003, -1, 0);
    read_line(64'h1000, 13'h0A5, -1, 0, -1);

    // Respack stall on beat 2
    read_line(64'h1000, 13'h0123, 2, 3, -1);

    // Write with a two-cycle reqcyc gap between beats 3 and 4
    for (int b = 0; b < 8; b++) wdata[b] = {$urandom, $urandom};
    write_line(64'h2040, 12'h07F, 4, 2);
    read_line(64'h2040, 13'h0042, -1, 0, -1);

    // Mid-line address: word order depends on the critical-word-first build
    read_line(64'h1018, 13'h0BEE, -1, 0, -1);

    // Reset during beat 4 of a read, then a full read
    read_line(64'h1000, 13'h0055, -1, 0, 4);
    @(negedge clk);
    check("post_rst_respcyc", bus.respcyc, 1'b0);
    read_line(64'h1000, 13'h0AAA, 1, $urandom_range(1, 3), -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Memory-side responder on the Sysbus; the far end of the bus the cache arbiter drives.
- Accepts one line request at a time.
  - Read: returns a full cache line as BEATS data beats after a programmable latency.
  - Write: absorbs BEATS data beats into internal storage.
- Used as the simulation memory model and as the template for the DRAM-controller front end.

Parameters:
- WIDTH, 64, bus data/address width in bits
- TAG_WIDTH, 13, request/response tag width
- BEATS, 8, beats per line (line = BEATS*WIDTH bits = 64 B)
- LINES, 1024, lines of backing storage (power of two)
- LATENCY, 20, cycles from read acceptance to first response beat (>=1)

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- req  in  WIDTH  byte address on the request cycle; write data on following beats
- reqtag  in  TAG_WIDTH  bit TAG_WIDTH-1 = 1 write / 0 read; remaining bits are an opaque id
- reqcyc  in  1  request/write-beat valid
- reqack  out  1  request or write beat accepted this cycle
- resp  out  WIDTH  read data beat
- resptag  out  TAG_WIDTH  tag echoed from the accepted read request
- respcyc  out  1  resp valid
- respack  in  1  requester consumed the current beat

Behaviour:
- All outputs are registered. Reset values: reqack=0, respcyc=0, resp=0, resptag=0; FSM to IDLE; counters to 0. Storage is not cleared by reset.
- Line index = req[log2(LINES)+5:6]. Address bits [5:3] = word offset; bits [2:0] are ignored. Upper bits alias.
- FSM states: IDLE, WDATA, WAIT, RESP.
- IDLE:
  - reqcyc=1 -> latch address and tag; reqack=1 next cycle.
  - Write tag -> WDATA, beat count 0.
  - Read tag -> WAIT, latency counter = LATENCY-1.
- WDATA:
  - Each cycle with reqcyc=1 stores req to word[beat] and pulses reqack; beat increments.
  - After beat BEATS-1 is stored -> IDLE. No response is sent for writes.
  - reqcyc=0 cycles are stalls; state and beat are held.
- WAIT: counter decrements each cycle. Moving from counter 0 to RESP gives a first respcyc exactly LATENCY+1 cycles after the request cycle.
- RESP:
  - respcyc=1; resp = word[beat]; resptag = latched tag.
  - respack=1 sampled while respcyc=1 -> advance to next beat next cycle; otherwise hold the same beat (no drop, no duplicate).
  - After the ack of the final beat: respcyc=0 next cycle -> IDLE.
  - The respcyc=0 cycle is mandatory; the arbiter uses it to detect end of transfer.
- reqcyc outside IDLE/WDATA: ignored, no reqack. The requester must hold the request until reqack.
- Simultaneous new reqcyc on the cycle RESP returns to IDLE: not accepted until the following cycle, when the FSM is in IDLE.
- Reset mid-transfer:
  - Abandons the transfer; respcyc and reqack drop the next cycle.
  - A partially written line keeps the beats already stored.
- Beat counter is log2(BEATS) bits and wraps modulo BEATS.

Optional Feature:
- SYSBUS_MEM_CRITICAL_WORD_FIRST_EN defined:
  - Read beats start at the word offset of the request address and wrap modulo BEATS.
  - Beat k returns word[(offset+k) mod BEATS].
- Undefined: reads always start at word 0; offset bits are ignored.
- Writes always start at word 0.

Decomposition:
- Shared package sysbus_pkg holds:
  - tag write-bit position constant
  - BEATS and line-offset constants
  - FSM state enum
  - helper function for line index extraction
- Sub-module sysbus_mem_array: single-port BEATS*LINES x WIDTH storage.
  - Synchronous write.
  - Combinational read addressed by {line, word}.
  - Instantiated once.

Test Plan:
- Reset, then idle 5 cycles -> reqack=0, respcyc=0, resp=0 throughout.
- Write line 0x1000 with data 0x11..0x88 (8 beats, reqcyc continuous), then read 0x1000 tag 0x0A5 -> first respcyc at cycle 21 after request; beats 0x11..0x88 in order; resptag=0x0A5; respcyc=0 on cycle after the last ack.
- Read with respack held low 3 cycles on beat 2 -> beat 2 value held stable for 4 cycles, then beat 3; still exactly 8 beats total.
- Write with reqcyc dropped between beats 3 and 4 for 2 cycles -> no reqack in gap; readback equals the written line.
- Read 0x1018 with SYSBUS_MEM_CRITICAL_WORD_FIRST_EN -> beats word3..7, word0..2. Without the macro -> word0..7.
- Assert reset during beat 4 of a read -> respcyc=0 next cycle. A new read then gets a full 8-beat response.
